// File: rtl/alarm_ctrl.sv
// Alarm controller: compares the running time against a programmed hh:mm and runs the ring/snooze/dismiss FSM.
// Define ALARM_BEEP_EN for a 1 s on / 1 s off buzzer while ringing; otherwise buzz is a steady copy of ringing.
module alarm_ctrl #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       arm,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzz,
    output logic [1:0] snooze_left
);

    localparam int CNT_MAX = (RING_TIMEOUT > SNOOZE_SEC) ? RING_TIMEOUT : SNOOZE_SEC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RING_LIM   = CW'(RING_TIMEOUT);
    localparam logic [CW-1:0] SNOOZE_LIM = CW'(SNOOZE_SEC);
    localparam logic [1:0]    SNOOZE_MAX = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] sec_cnt, cnt_nxt, cnt_inc;
    logic [1:0]    left_nxt;
    logic          match, match_d, trigger;

    // Only the first cycle at hh:mm:00 fires, so a stalled clock chain cannot retrigger.
    assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
    assign trigger = match && !match_d;
    assign cnt_inc = sec_cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = sec_cnt;
        left_nxt  = snooze_left;
        if (!arm) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (set_en) begin
            if (state != IDLE) begin
                state_nxt = ARMED;
                cnt_nxt   = '0;
            end
        end else begin
            unique case (state)
                IDLE: state_nxt = ARMED;
                ARMED: begin
                    if (trigger) begin
                        state_nxt = RINGING;
                        cnt_nxt   = '0;
                        left_nxt  = SNOOZE_MAX;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                    end else if (snooze && (snooze_left != 2'd0)) begin
                        state_nxt = SNOOZE;
                        cnt_nxt   = '0;
                        left_nxt  = snooze_left - 2'd1;
                    end else if (sec_tick) begin
                        if (cnt_inc == RING_LIM) begin
                            state_nxt = ARMED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                    end else if (sec_tick) begin
                        if (cnt_inc == SNOOZE_LIM) begin
                            state_nxt = RINGING;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Alarm time loads on any set_en, so it can be programmed before arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            snooze_left <= SNOOZE_MAX;
            match_d     <= 1'b0;
            alarm_hour  <= '0;
            alarm_min   <= '0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            buzz        <= 1'b0;
        end else begin
            state       <= state_nxt;
            sec_cnt     <= cnt_nxt;
            snooze_left <= left_nxt;
            match_d     <= match;
            if (set_en) begin
                alarm_hour <= set_hour;
                alarm_min  <= set_min;
            end
            ringing  <= (state_nxt == RINGING);
            snoozing <= (state_nxt == SNOOZE);
`ifdef ALARM_BEEP_EN
            buzz <= (state_nxt == RINGING) && ((state != RINGING) || (sec_tick ? !buzz : buzz));
`else
            buzz <= (state_nxt == RINGING);
`endif
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short timeouts (RING_TIMEOUT=5, SNOOZE_SEC=3, MAX_SNOOZE=2).
// Expected buzz values follow the ALARM_BEEP_EN build setting.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       set_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       arm;
    logic       snooze;
    logic       dismiss;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       ringing;
    logic       snoozing;
    logic       buzz;
    logic [1:0] snooze_left;

    int total = 0;
    int bad   = 0;

`ifdef ALARM_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    alarm_ctrl #(
        .RING_TIMEOUT(5),
        .SNOOZE_SEC  (3),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .set_en     (set_en),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .arm        (arm),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .buzz       (buzz),
        .snooze_left(snooze_left)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h;
        cur_min  = m;
        cur_sec  = s;
    endtask

    task automatic pulse_tick();
        sec_tick = 1'b1;
        applyStimulus(1);
        sec_tick = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        applyStimulus(1);
        snooze = 1'b0;
    endtask

    task automatic pulse_dismiss();
        dismiss = 1'b1;
        applyStimulus(1);
        dismiss = 1'b0;
    endtask

    task automatic load_alarm(input logic [4:0] h, input logic [5:0] m);
        set_hour = h;
        set_min  = m;
        set_en   = 1'b1;
        applyStimulus(1);
        set_en   = 1'b0;
    endtask

    // Second 59 then second 0 of the given minute: ringing appears after the second step.
    task automatic reach_minute(input logic [4:0] h, input logic [5:0] m);
        set_time(h, m, 6'd59);
        applyStimulus(1);
        set_time(h, m, 6'd0);
        applyStimulus(1);
    endtask

    initial begin
        rst = 1'b1;
        sec_tick = 1'b0;
        set_en = 1'b0;
        set_hour = '0;
        set_min = '0;
        arm = 1'b0;
        snooze = 1'b0;
        dismiss = 1'b0;
        set_time(5'd7, 6'd29, 6'd59);
        applyStimulus(2);
        checkOutput("rst_alarm_hour", 8'(alarm_hour), 8'd0);
        checkOutput("rst_alarm_min", 8'(alarm_min), 8'd0);
        checkOutput("rst_ringing", 8'(ringing), 8'd0);
        checkOutput("rst_snoozing", 8'(snoozing), 8'd0);
        checkOutput("rst_buzz", 8'(buzz), 8'd0);
        checkOutput("rst_snooze_left", 8'(snooze_left), 8'd2);
        rst = 1'b0;
        applyStimulus(1);

        arm = 1'b1;
        applyStimulus(1);
        pulse_snooze();
        checkOutput("armed_snooze_noeffect", 8'(snoozing), 8'd0);
        load_alarm(5'd7, 6'd30);
        checkOutput("set_hour_0730", 8'(alarm_hour), 8'd7);
        checkOutput("set_min_0730", 8'(alarm_min), 8'd30);

        set_time(5'd7, 6'd30, 6'd0);
        #1;
        checkOutput("ring_not_yet", 8'(ringing), 8'd0);
        applyStimulus(1);
        checkOutput("ring_start", 8'(ringing), 8'd1);
        checkOutput("ring_start_buzz", 8'(buzz), 8'd1);
        checkOutput("ring_start_left", 8'(snooze_left), 8'd2);
        for (int k = 1; k <= 4; k++) begin
            pulse_tick();
            checkOutput("ring_hold", 8'(ringing), 8'd1);
            checkOutput("ring_buzz", 8'(buzz), BEEP ? 8'((k % 2) == 0) : 8'd1);
        end
        pulse_tick();
        checkOutput("ring_timeout", 8'(ringing), 8'd0);
        checkOutput("ring_timeout_buzz", 8'(buzz), 8'd0);
        applyStimulus(10);
        checkOutput("timeout_no_retrigger", 8'(ringing), 8'd0);

        reach_minute(5'd7, 6'd30);
        checkOutput("snz_ring", 8'(ringing), 8'd1);
        pulse_snooze();
        checkOutput("snz1_snoozing", 8'(snoozing), 8'd1);
        checkOutput("snz1_ringing", 8'(ringing), 8'd0);
        checkOutput("snz1_left", 8'(snooze_left), 8'd1);
        checkOutput("snz1_buzz", 8'(buzz), 8'd0);
        pulse_tick();
        pulse_tick();
        checkOutput("snz1_still", 8'(snoozing), 8'd1);
        pulse_tick();
        checkOutput("snz1_resume", 8'(ringing), 8'd1);
        checkOutput("snz1_resume_snoozing", 8'(snoozing), 8'd0);
        checkOutput("snz1_resume_left", 8'(snooze_left), 8'd1);
        checkOutput("snz1_resume_buzz", 8'(buzz), 8'd1);
        pulse_snooze();
        checkOutput("snz2_left", 8'(snooze_left), 8'd0);
        checkOutput("snz2_snoozing", 8'(snoozing), 8'd1);
        repeat (3) pulse_tick();
        checkOutput("snz2_resume", 8'(ringing), 8'd1);
        pulse_snooze();
        checkOutput("snz3_ignored_ring", 8'(ringing), 8'd1);
        checkOutput("snz3_ignored_snoozing", 8'(snoozing), 8'd0);
        checkOutput("snz3_ignored_left", 8'(snooze_left), 8'd0);
        pulse_dismiss();
        checkOutput("dismiss_ring", 8'(ringing), 8'd0);

        reach_minute(5'd7, 6'd30);
        checkOutput("retrig_ring", 8'(ringing), 8'd1);
        checkOutput("retrig_left_reload", 8'(snooze_left), 8'd2);
        snooze = 1'b1;
        dismiss = 1'b1;
        applyStimulus(1);
        snooze = 1'b0;
        dismiss = 1'b0;
        checkOutput("both_ringing", 8'(ringing), 8'd0);
        checkOutput("both_snoozing", 8'(snoozing), 8'd0);
        checkOutput("both_left", 8'(snooze_left), 8'd2);
        applyStimulus(10);
        checkOutput("hold_no_retrigger", 8'(ringing), 8'd0);

        reach_minute(5'd7, 6'd30);
        pulse_snooze();
        checkOutput("snz_before_dismiss", 8'(snoozing), 8'd1);
        pulse_dismiss();
        checkOutput("snz_dismiss_snoozing", 8'(snoozing), 8'd0);
        checkOutput("snz_dismiss_ringing", 8'(ringing), 8'd0);

        reach_minute(5'd7, 6'd30);
        checkOutput("disarm_pre_ring", 8'(ringing), 8'd1);
        arm = 1'b0;
        applyStimulus(1);
        checkOutput("disarm_ringing", 8'(ringing), 8'd0);
        checkOutput("disarm_buzz", 8'(buzz), 8'd0);
        arm = 1'b1;
        applyStimulus(1);
        load_alarm(5'd8, 6'd0);
        checkOutput("set_hour_0800", 8'(alarm_hour), 8'd8);
        checkOutput("set_min_0800", 8'(alarm_min), 8'd0);
        reach_minute(5'd7, 6'd30);
        applyStimulus(1);
        checkOutput("old_time_silent", 8'(ringing), 8'd0);
        reach_minute(5'd8, 6'd0);
        checkOutput("new_time_rings", 8'(ringing), 8'd1);

        pulse_snooze();
        checkOutput("pre_rst_snoozing", 8'(snoozing), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_snoozing", 8'(snoozing), 8'd0);
        checkOutput("async_buzz", 8'(buzz), 8'd0);
        checkOutput("async_ringing", 8'(ringing), 8'd0);
        checkOutput("async_alarm_hour", 8'(alarm_hour), 8'd0);
        checkOutput("async_snooze_left", 8'(snooze_left), 8'd2);
        rst = 1'b0;
        applyStimulus(2);

        load_alarm(5'd25, 6'd61);
        checkOutput("oor_hour", 8'(alarm_hour), 8'd25);
        checkOutput("oor_min", 8'(alarm_min), 8'd61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
